// File: rtl/imem_loader.sv
// Instruction memory for mips_core: loads a big-endian byte stream into 32-bit words,
// holds the core in reset while loading, then serves instr for pc combinationally.
module imem_loader #(
  parameter int DEPTH       = 256,
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_start,
  input  logic                     load_valid,
  input  logic [7:0]               load_byte,
  input  logic                     load_last,
  output logic                     load_ready,
  input  logic [PC_WIDTH-1:0]      pc,
  output logic [INSTR_WIDTH-1:0]   instr,
  output logic                     core_rst_n,
  output logic                     busy,
  output logic                     load_done,
  output logic [$clog2(DEPTH):0]   word_count,
  output logic                     err_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t                 state_q;
  logic [1:0]             byte_cnt_q;
  logic [INSTR_WIDTH-1:0] word_q;
  logic [AW:0]            count_q;
  logic                   err_q;
  logic                   done_q;
  logic                   core_rst_n_q;

  logic [INSTR_WIDTH-1:0] mem [DEPTH];

  logic                   accept;
  logic                   mem_full;
  logic                   word_end;
  logic                   mem_we;
  logic [INSTR_WIDTH-1:0] word_d;

  assign accept   = (state_q == LOAD) && load_valid;
  assign mem_full = (count_q == DEPTH_W);
  assign word_end = (byte_cnt_q == 2'd3) || load_last;
  assign mem_we   = accept && word_end && !mem_full && !rst;

  // Lanes not yet written stay zero in word_q, so an early load_last pads for free.
  assign word_d = word_q | ({{(INSTR_WIDTH-8){1'b0}}, load_byte} << {~byte_cnt_q, 3'b000});

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[count_q[AW-1:0]] <= word_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      byte_cnt_q   <= 2'd0;
      word_q       <= '0;
      count_q      <= '0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      core_rst_n_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_start) begin
            state_q    <= LOAD;
            byte_cnt_q <= 2'd0;
            word_q     <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
          end
        end
        LOAD: begin
          if (load_valid) begin
            // A full memory means byte_cnt is 0, so no partial word is ever lost here.
            if (mem_full) begin
              err_q <= 1'b1;
            end else if (word_end) begin
              count_q    <= count_q + 1'b1;
              byte_cnt_q <= 2'd0;
              word_q     <= '0;
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
              word_q     <= word_d;
            end
            if (load_last) begin
              state_q <= RUN;
              done_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (load_start) begin
            state_q      <= LOAD;
            core_rst_n_q <= 1'b0;
            byte_cnt_q   <= 2'd0;
            word_q       <= '0;
            count_q      <= '0;
            err_q        <= 1'b0;
          end else begin
            core_rst_n_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign load_ready   = (state_q == LOAD);
  assign busy         = (state_q == LOAD);
  assign load_done    = done_q;
  assign core_rst_n   = core_rst_n_q;
  assign word_count   = count_q;
  assign err_overflow = err_q;

  // Reads beyond the loaded program return 0, which the core decodes as a nop.
  logic [PC_WIDTH-3:0] pc_word;
  logic                unused_pc;
  assign pc_word   = pc[PC_WIDTH-1:2];
  assign unused_pc = ^pc[1:0];
  assign instr = (pc_word < {{(PC_WIDTH-3-AW){1'b0}}, count_q}) ? mem[pc[AW+1:2]] : '0;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a 256-word and a 4-word instance share one stimulus stream.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic        load_valid;
  logic [7:0]  load_byte;
  logic        load_last;
  logic [31:0] pc;

  logic        ready_a, core_a, busy_a, done_a, err_a;
  logic [31:0] instr_a;
  logic [8:0]  wc_a;

  logic        ready_b, core_b, busy_b, done_b, err_b;
  logic [31:0] instr_b;
  logic [2:0]  wc_b;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] prog [8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(256), .PC_WIDTH(32), .INSTR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid),
    .load_byte(load_byte), .load_last(load_last), .load_ready(ready_a), .pc(pc),
    .instr(instr_a), .core_rst_n(core_a), .busy(busy_a), .load_done(done_a),
    .word_count(wc_a), .err_overflow(err_a)
  );

  imem_loader #(.DEPTH(4), .PC_WIDTH(32), .INSTR_WIDTH(32)) dut4 (
    .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid),
    .load_byte(load_byte), .load_last(load_last), .load_ready(ready_b), .pc(pc),
    .instr(instr_b), .core_rst_n(core_b), .busy(busy_b), .load_done(done_b),
    .word_count(wc_b), .err_overflow(err_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  // Present one byte and hold it until accepted (bounded).
  task automatic send(input logic [7:0] b, input logic last);
    int n = 0;
    load_valid = 1'b1;
    load_byte  = b;
    load_last  = last;
    while (!ready_a && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready_a) check("send_timeout", 64'd0, 64'd1);
    @(negedge clk);
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  // Idle cycles with junk on the bus and load_last high but load_valid low.
  task automatic gap(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      load_valid = 1'b0;
      load_byte  = 8'hFF;
      load_last  = 1'b1;
      @(negedge clk);
    end
    load_last = 1'b0;
  endtask

  task automatic read_a(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    pc = addr;
    #1;
    check(tag, 64'(instr_a), 64'(exp));
  endtask

  initial begin
    rst = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_byte = 8'h00;
    load_last = 1'b0; pc = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("rst_busy",       64'(busy_a),  64'd0);
    check("rst_ready",      64'(ready_a), 64'd0);
    check("rst_core_rst_n", 64'(core_a),  64'd0);
    check("rst_word_count", 64'(wc_a),    64'd0);
    check("rst_err",        64'(err_a),   64'd0);
    check("rst_done",       64'(done_a),  64'd0);
    read_a(32'd0, 32'h0, "rst_instr0");

    // Bytes offered in IDLE must be ignored.
    load_valid = 1'b1; load_byte = 8'hFF; load_last = 1'b1;
    repeat (2) @(negedge clk);
    load_valid = 1'b0; load_last = 1'b0;
    check("idle_no_accept_wc", 64'(wc_a),   64'd0);
    check("idle_no_done",      64'(done_a), 64'd0);
    check("idle_busy",         64'(busy_a), 64'd0);

    // Basic 8-byte program.
    pulse_start();
    check("load_busy",  64'(busy_a),  64'd1);
    check("load_ready", 64'(ready_a), 64'd1);
    for (int i = 0; i < 8; i++) send(prog[i], i == 7);
    check("p1_done_pulse", 64'(done_a), 64'd1);
    check("p1_core_low",   64'(core_a), 64'd0);
    check("p1_not_busy",   64'(busy_a), 64'd0);
    @(negedge clk);
    check("p1_done_cleared", 64'(done_a), 64'd0);
    check("p1_core_high",    64'(core_a), 64'd1);
    check("p1_wc",           64'(wc_a),   64'd2);
    read_a(32'd0, 32'h2008_0005, "p1_mem0");
    read_a(32'd4, 32'h2009_0007, "p1_mem1");
    read_a(32'd5, 32'h2009_0007, "p1_mem1_lowbits");
    read_a(32'd8, 32'h0000_0000, "p1_past_end");

    // Bytes offered in RUN must be ignored.
    load_valid = 1'b1; load_byte = 8'h55; load_last = 1'b1;
    repeat (3) @(negedge clk);
    load_valid = 1'b0; load_last = 1'b0;
    check("run_ready",        64'(ready_a), 64'd0);
    check("run_no_accept_wc", 64'(wc_a),    64'd2);
    read_a(32'd0, 32'h2008_0005, "run_mem0_kept");

    // Partial final word, with a load_start during LOAD that must be ignored.
    pulse_start();
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    pulse_start();
    send(8'hCC, 1'b0);
    send(8'hDD, 1'b0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b1);
    @(negedge clk);
    check("p2_wc",  64'(wc_a),  64'd2);
    check("p2_err", 64'(err_a), 64'd0);
    read_a(32'd0, 32'hAABB_CCDD, "p2_mem0");
    read_a(32'd4, 32'h1122_0000, "p2_mem1_padded");

    // Same program with random gaps between bytes.
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      gap($urandom_range(0, 3));
      send(prog[i], i == 7);
    end
    @(negedge clk);
    check("p3_wc", 64'(wc_a), 64'd2);
    read_a(32'd0, 32'h2008_0005, "p3_mem0");
    read_a(32'd4, 32'h2009_0007, "p3_mem1");

    // Overflow on the 4-word instance: bytes 01..14 (20 bytes).
    pulse_start();
    for (int i = 1; i <= 20; i++) begin
      send(8'(i), i == 20);
      if (i == 16) begin
        check("ov_err_before", 64'(err_b), 64'd0);
        check("ov_wc_full",    64'(wc_b),  64'd4);
      end
      if (i == 17) check("ov_err_after", 64'(err_b), 64'd1);
    end
    check("ov_done",     64'(done_b), 64'd1);
    check("ov_in_run",   64'(busy_b), 64'd0);
    check("ov_wc_sat",   64'(wc_b),   64'd4);
    pc = 32'd0;  #1; check("ov_mem0", 64'(instr_b), 64'h0102_0304);
    pc = 32'd12; #1; check("ov_mem3", 64'(instr_b), 64'h0D0E_0F10);
    pc = 32'd16; #1; check("ov_past_end", 64'(instr_b), 64'h0);
    check("ov_big_wc",  64'(wc_a),    64'd5);
    check("ov_big_err", 64'(err_a),   64'd0);
    check("ov_big_w4",  64'(instr_a), 64'h1112_1314);
    @(negedge clk);
    check("ov_core_high", 64'(core_b), 64'd1);

    // Reload from RUN.
    pulse_start();
    check("rl_core_low",  64'(core_b), 64'd0);
    check("rl_err_clear", 64'(err_b),  64'd0);
    check("rl_busy",      64'(busy_b), 64'd1);
    send(8'hDE, 1'b0);
    send(8'hAD, 1'b0);
    send(8'hBE, 1'b0);
    send(8'hEF, 1'b1);
    @(negedge clk);
    check("rl_wc",  64'(wc_b), 64'd1);
    pc = 32'd0; #1; check("rl_mem0",     64'(instr_b), 64'hDEAD_BEEF);
    pc = 32'd4; #1; check("rl_past_end", 64'(instr_b), 64'h0);

    // Reset in the middle of a load.
    pulse_start();
    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    send(8'h56, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mr_busy",   64'(busy_a),  64'd0);
    check("mr_ready",  64'(ready_a), 64'd0);
    check("mr_wc",     64'(wc_a),    64'd0);
    check("mr_core",   64'(core_a),  64'd0);
    read_a(32'd0, 32'h0, "mr_instr0");
    repeat (3) @(negedge clk);
    check("mr_core_stays_low", 64'(core_a), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
